instr_fetch_decode: RTL and testbench

Sequential instruction fetch-and-decode engine for the single-cycle MIPS datapath labs. On a start pulse it walks a block of instruction memory from a programmable word-aligned base address and reads a programmable number of words through the shared `mem` read port. It splits each word into R/I/J fields and presents them on a valid/ready output stream. Per-type instruction counts are kept for the run. It replaces hand-stepped display loops as the front end for decoder and control-unit verification.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/instr_field_decode.sv | 44 ++++
 rtl/instr_fetch_decode.sv | 163 ++++++++++++++++
 tb/tb_instr_fetch_decode.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared opcode constants, instruction-type encodings and the
//               fetch/decode state encoding for the MIPS lab datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

   // Opcodes that select the non-I instruction formats
   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_JAL   = 6'd3;

   // Instruction format as presented on the itype output
   typedef enum logic [1:0] {
      IT_R = 2'd0,
      IT_I = 2'd1,
      IT_J = 2'd2
   } itype_t;

   // Fetch/decode sequencer states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_OUT  = 3'd3,
      ST_FIN  = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_field_decode.sv
`default_nettype none
// ============================================================================
// Module      : instr_field_decode
// Description : Purely combinational split of a 32-bit MIPS word into its
//               R/I/J fields, sign-extended immediate and format class.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_field_decode
   import mips_pkg::*;
(
   input  logic [31:0] word,
   output logic [1:0]  itype,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic [31:0] imm_sext,
   output logic [25:0] target
);

   // All fields are driven for every word; consumers pick what they need
   assign opcode   = word[31:26];
   assign rs       = word[25:21];
   assign rt       = word[20:16];
   assign rd       = word[15:11];
   assign shamt    = word[10:6];
   assign funct    = word[5:0];
   assign imm_sext = {{16{word[15]}}, word[15:0]};
   assign target   = word[25:0];

   // Format class: opcode 0 is R, j/jal are J, everything else is I
   always_comb begin
      itype = IT_I;
      case (word[31:26])
         OP_RTYPE:     itype = IT_R;
         OP_J, OP_JAL: itype = IT_J;
         default:      itype = IT_I;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_decode
// Description : Walks a block of instruction memory from a word-aligned base,
//               decodes each word and streams it out over valid/ready while
//               keeping per-format instruction counts for the run.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_decode
   import mips_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int CNT_W   = 8,
   parameter int MEM_LAT = 0
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  count,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   input  logic [31:0]       mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        itype,
   output logic [5:0]        opcode,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [4:0]        rd,
   output logic [4:0]        shamt,
   output logic [5:0]        funct,
   output logic [31:0]       imm_sext,
   output logic [25:0]       target,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  r_cnt,
   output logic [CNT_W-1:0]  i_cnt,
   output logic [CNT_W-1:0]  j_cnt
);

   // Value of the wait counter in the cycle whose end carries read data
   localparam logic [1:0] c_LAST_WAIT = (MEM_LAT == 0) ? 2'd0 : 2'(MEM_LAT - 1);

   state_t             r_state;
   state_t             w_next;
   logic [ADDR_W-1:0]  r_addr;
   logic [CNT_W-1:0]   r_remaining;
   logic [31:0]        r_word;
   logic [1:0]         r_wait;
   logic [CNT_W-1:0]   r_rtype_cnt;
   logic [CNT_W-1:0]   r_itype_cnt;
   logic [CNT_W-1:0]   r_jtype_cnt;
   logic [ADDR_W-1:0]  w_base_aligned;

   // Masking rather than slicing keeps the ignored low address bits explicit
   assign w_base_aligned = base_addr & ~ADDR_W'(3);

   // The fetch address doubles as the pc of the word currently held
   assign mem_addr = r_addr;
   assign pc       = r_addr;
   assign r_cnt    = r_rtype_cnt;
   assign i_cnt    = r_itype_cnt;
   assign j_cnt    = r_jtype_cnt;

   instr_field_decode u_decode (
      .word     (r_word),
      .itype    (itype),
      .opcode   (opcode),
      .rs       (rs),
      .rt       (rt),
      .rd       (rd),
      .shamt    (shamt),
      .funct    (funct),
      .imm_sext (imm_sext),
      .target   (target)
   );

   // State register; reset aborts any run in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Next-state and strobe decode
   always_comb begin
      w_next    = r_state;
      mem_read  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) w_next = (count != '0) ? ST_REQ : ST_FIN;
         end
         ST_REQ: begin
            mem_read = 1'b1;
            w_next   = (MEM_LAT == 0) ? ST_OUT : ST_WAIT;
         end
         ST_WAIT: begin
            if (r_wait == c_LAST_WAIT) w_next = ST_OUT;
         end
         ST_OUT: begin
            out_valid = 1'b1;
            if (out_ready) w_next = (r_remaining == CNT_W'(1)) ? ST_FIN : ST_REQ;
         end
         ST_FIN: begin
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Run bookkeeping: address walk, word capture and saturating type counts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr      <= '0;
         r_remaining <= '0;
         r_word      <= '0;
         r_wait      <= '0;
         r_rtype_cnt <= '0;
         r_itype_cnt <= '0;
         r_jtype_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start && (count != '0)) begin
                  r_addr      <= w_base_aligned;
                  r_remaining <= count;
                  r_rtype_cnt <= '0;
                  r_itype_cnt <= '0;
                  r_jtype_cnt <= '0;
               end
            end
            ST_REQ: begin
               r_wait <= '0;
               if (MEM_LAT == 0) r_word <= mem_rdata;
            end
            ST_WAIT: begin
               r_wait <= r_wait + 2'd1;
               if (r_wait == c_LAST_WAIT) r_word <= mem_rdata;
            end
            ST_OUT: begin
               if (out_ready) begin
                  r_addr      <= r_addr + ADDR_W'(4);
                  r_remaining <= r_remaining - CNT_W'(1);
                  case (itype)
                     IT_R:    if (r_rtype_cnt != '1) r_rtype_cnt <= r_rtype_cnt + CNT_W'(1);
                     IT_J:    if (r_jtype_cnt != '1) r_jtype_cnt <= r_jtype_cnt + CNT_W'(1);
                     default: if (r_itype_cnt != '1) r_itype_cnt <= r_itype_cnt + CNT_W'(1);
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_decode
// Description : Directed self-checking bench; one DUT with zero-latency
//               memory, one with three-cycle pipelined memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_decode;
   import mips_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // DUT A: MEM_LAT = 0
   logic        start_a, rdy_a, mr_a, ov_a, busy_a, done_a;
   logic [31:0] base_a, maddr_a, rdata_a, imm_a, pc_a;
   logic [7:0]  cnt_a, rc_a, ic_a, jc_a;
   logic [1:0]  it_a;
   logic [5:0]  op_a, fn_a;
   logic [4:0]  rs_a, rt_a, rd_a, sh_a;
   logic [25:0] tg_a;
   // DUT B: MEM_LAT = 3
   logic        start_b, rdy_b, mr_b, ov_b, busy_b, done_b;
   logic [31:0] base_b, maddr_b, rdata_b, imm_b, pc_b;
   logic [7:0]  cnt_b, rc_b, ic_b, jc_b;
   logic [1:0]  it_b;
   logic [5:0]  op_b, fn_b;
   logic [4:0]  rs_b, rt_b, rd_b, sh_b;
   logic [25:0] tg_b;

   logic [31:0] mem [0:63];
   int total = 0;
   int bad   = 0;

   // Zero-latency memory is a plain lookup
   assign rdata_a = mem[maddr_a[7:2]];

   // Three-cycle memory: data only appears exactly three cycles after the strobe
   logic [2:0]  pv = 3'b000;
   logic [31:0] pa0, pa1, pa2;
   always @(posedge clk) begin
      pv  <= {pv[1:0], mr_b};
      pa0 <= maddr_b;
      pa1 <= pa0;
      pa2 <= pa1;
   end
   assign rdata_b = pv[2] ? mem[pa2[7:2]] : 32'hDEADBEEF;

   instr_fetch_decode #(.ADDR_W(32), .CNT_W(8), .MEM_LAT(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .base_addr(base_a), .count(cnt_a),
      .mem_addr(maddr_a), .mem_read(mr_a), .mem_rdata(rdata_a),
      .out_valid(ov_a), .out_ready(rdy_a), .itype(it_a), .opcode(op_a),
      .rs(rs_a), .rt(rt_a), .rd(rd_a), .shamt(sh_a), .funct(fn_a),
      .imm_sext(imm_a), .target(tg_a), .pc(pc_a), .busy(busy_a), .done(done_a),
      .r_cnt(rc_a), .i_cnt(ic_a), .j_cnt(jc_a)
   );

   instr_fetch_decode #(.ADDR_W(32), .CNT_W(8), .MEM_LAT(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .base_addr(base_b), .count(cnt_b),
      .mem_addr(maddr_b), .mem_read(mr_b), .mem_rdata(rdata_b),
      .out_valid(ov_b), .out_ready(rdy_b), .itype(it_b), .opcode(op_b),
      .rs(rs_b), .rt(rt_b), .rd(rd_b), .shamt(sh_b), .funct(fn_b),
      .imm_sext(imm_b), .target(tg_b), .pc(pc_b), .busy(busy_b), .done(done_b),
      .r_cnt(rc_b), .i_cnt(ic_b), .j_cnt(jc_b)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] cls(input logic [31:0] w);
      case (w[31:26])
         6'd0:       return 2'd0;
         6'd2, 6'd3: return 2'd2;
         default:    return 2'd1;
      endcase
   endfunction

   // Runs one block on DUT A (sel=0) or B (sel=1) and checks the stream
   task automatic run(input bit sel, input logic [31:0] base, input logic [7:0] n,
                      input bit rand_rdy, input int exp_space, input int poke,
                      input int er, input int ei, input int ej);
      logic [31:0] a0, ea, w, p, ma, sw, spc;
      logic        v, mr, dn, rdy, bz;
      logic [1:0]  it;
      logic [7:0]  rc, ic, jc;
      int k, reads, dones, prev;
      bit stalled;
      a0 = base & ~32'd3;
      k = 0; reads = 0; dones = 0; prev = -1; stalled = 0;
      sw = '0; spc = '0;
      if (sel) begin start_b = 1'b1; base_b = base; cnt_b = n; end
      else     begin start_a = 1'b1; base_a = base; cnt_a = n; end
      step();
      for (int cyc = 0; cyc < 400 && dones == 0; cyc++) begin
         rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         if (sel) begin
            rdy_b = rdy; start_b = (cyc == poke);
            if (cyc == poke) begin base_b = 32'h0; cnt_b = 8'd5; end
         end else begin
            rdy_a = rdy; start_a = (cyc == poke);
            if (cyc == poke) begin base_a = 32'h0; cnt_a = 8'd5; end
         end
         v  = sel ? ov_b : ov_a;
         mr = sel ? mr_b : mr_a;
         dn = sel ? done_b : done_a;
         ma = sel ? maddr_b : maddr_a;
         p  = sel ? pc_b : pc_a;
         it = sel ? it_b : it_a;
         w  = sel ? {op_b, rs_b, rt_b, rd_b, sh_b, fn_b} : {op_a, rs_a, rt_a, rd_a, sh_a, fn_a};
         if (mr) begin
            ea = a0 + 32'(4 * reads);
            chk("rd_addr", ma, ea);
            chk("rd_while_valid", v, 0);
            if (exp_space > 0 && prev >= 0) chk("rd_spacing", cyc - prev, exp_space);
            prev = cyc;
            reads++;
         end
         if (v) begin
            if (stalled) begin
               chk("stall_word", w, sw);
               chk("stall_pc", p, spc);
            end
            if (rdy) begin
               ea = a0 + 32'(4 * k);
               chk("word", w, mem[ea[7:2]]);
               chk("pc", p, ea);
               chk("itype", it, cls(mem[ea[7:2]]));
               k++;
               stalled = 0;
            end else begin
               stalled = 1; sw = w; spc = p;
            end
         end
         if (dn) dones++;
         else    step();
      end
      start_a = 1'b0; start_b = 1'b0;
      rc = sel ? rc_b : rc_a;
      ic = sel ? ic_b : ic_a;
      jc = sel ? jc_b : jc_a;
      chk("handshakes", k, n);
      chk("reads", reads, n);
      chk("done_seen", dones, 1);
      chk("r_cnt", rc, er);
      chk("i_cnt", ic, ei);
      chk("j_cnt", jc, ej);
      step();
      dn = sel ? done_b : done_a;
      bz = sel ? busy_b : busy_a;
      chk("done_one_cycle", dn, 0);
      chk("busy_after_done", bz, 0);
   endtask

   // Directed sequence
   initial begin
      rst_n = 1'b0;
      start_a = 1'b0; rdy_a = 1'b1; base_a = '0; cnt_a = '0;
      start_b = 1'b0; rdy_b = 1'b1; base_b = '0; cnt_b = '0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h2400_0000 | 32'(i);
      mem[32] = 32'h012A4020; mem[33] = 32'h2108FFFF; mem[34] = 32'h08000020;
      mem[35] = 32'h00000000; mem[36] = 32'h8C220004; mem[37] = 32'h0C000010;
      mem[38] = 32'h10220003; mem[39] = 32'h00851022; mem[40] = 32'hAC220008;
      mem[41] = 32'h3C011234; mem[42] = 32'h0000000C;
      mem[63] = 32'h00000020; mem[0]  = 32'h08000001;
      step(); step();

      // Reset state
      chk("rst_mem_read", mr_a, 0);
      chk("rst_out_valid", ov_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_mem_addr", maddr_a, 0);
      chk("rst_pc", pc_a, 0);
      chk("rst_fields", {op_a, imm_a, tg_a}, 0);
      chk("rst_counts", {rc_a, ic_a, jc_a}, 0);
      chk("rst_busy_b", busy_b, 0);
      rst_n = 1'b1;
      step();

      // Three-word image, ready held high, cycle-exact
      start_a = 1'b1; base_a = 32'd128; cnt_a = 8'd3;
      step(); start_a = 1'b0;
      chk("r1_req1", {mr_a, busy_a, ov_a}, 3'b110);
      chk("r1_addr1", maddr_a, 128);
      step();
      chk("r1_w1_valid", ov_a, 1);
      chk("r1_w1_type", it_a, 0);
      chk("r1_w1_regs", {rs_a, rt_a, rd_a, sh_a, fn_a}, {5'd9, 5'd10, 5'd8, 5'd0, 6'd32});
      chk("r1_w1_pc", pc_a, 128);
      step();
      chk("r1_req2", {mr_a, ov_a}, 2'b10);
      chk("r1_addr2", maddr_a, 132);
      step();
      chk("r1_w2_type", it_a, 1);
      chk("r1_w2_fields", {op_a, rs_a, rt_a}, {6'd8, 5'd8, 5'd8});
      chk("r1_w2_imm", imm_a, 32'hFFFFFFFF);
      chk("r1_w2_pc", pc_a, 132);
      step();
      chk("r1_addr3", {mr_a, maddr_a}, {1'b1, 32'd136});
      step();
      chk("r1_w3_type", it_a, 2);
      chk("r1_w3_target", tg_a, 26'h20);
      chk("r1_w3_pc", pc_a, 136);
      step();
      chk("r1_done", {done_a, busy_a, ov_a}, 3'b110);
      chk("r1_counts", {rc_a, ic_a, jc_a}, {8'd1, 8'd1, 8'd1});
      step();
      chk("r1_idle", {done_a, busy_a}, 2'b00);
      chk("r1_counts_hold", {rc_a, ic_a, jc_a}, {8'd1, 8'd1, 8'd1});

      // Same image with random back-pressure
      run(1'b0, 32'd128, 8'd3, 1'b1, 0, -1, 1, 1, 1);
      // Eleven words, both latencies
      run(1'b0, 32'd128, 8'd11, 1'b0, 2, -1, 4, 5, 2);
      run(1'b1, 32'd128, 8'd11, 1'b0, 5, -1, 4, 5, 2);
      // Address wrap from an unaligned base
      run(1'b0, 32'hFFFFFFFE, 8'd2, 1'b0, 2, -1, 1, 0, 1);

      // Zero-count run
      start_a = 1'b1; base_a = 32'd128; cnt_a = 8'd0;
      step(); start_a = 1'b0;
      chk("z_done", {done_a, mr_a, busy_a}, 3'b101);
      step();
      chk("z_idle", {done_a, mr_a, busy_a}, 3'b000);

      // start pulsed mid-run must be ignored
      run(1'b0, 32'd128, 8'd3, 1'b0, 2, 3, 1, 1, 1);

      // Reset while stalled in OUT
      rdy_a = 1'b1; start_a = 1'b1; base_a = 32'd128; cnt_a = 8'd3;
      step(); start_a = 1'b0;
      step();
      step(); rdy_a = 1'b0;
      step();
      chk("pre_rst_state", {ov_a, busy_a, rc_a}, {1'b1, 1'b1, 8'd1});
      rst_n = 1'b0;
      #1;
      chk("mid_rst_outs", {ov_a, busy_a, mr_a}, 3'b000);
      chk("mid_rst_counts", {rc_a, ic_a, jc_a}, 0);
      step();
      rst_n = 1'b1; rdy_a = 1'b1;
      step();
      chk("post_rst_idle", {ov_a, busy_a, done_a, mr_a}, 4'b0000);
      step();
      chk("post_rst_stay", {ov_a, busy_a, done_a, mr_a}, 4'b0000);
      run(1'b0, 32'd132, 8'd1, 1'b0, 0, -1, 0, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
